// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the Fetch stage sequencing controller and datapath.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BR_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_HOLD   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_ZERO   = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    IR_MEM  = 2'd0,
    IR_HOLD = 2'd1,
    IR_NOP  = 2'd2
  } ir_sel_t;

  // Instruction word injected into the fetch latch when IR_NOP is selected.
  localparam logic [31:0] NOP_INSTR = 32'hFF000000;

  // Bits needed to hold 0..timeout inclusive; never narrower than one bit.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter updated on the falling clock edge.
module sat_counter
  #(
    parameter int unsigned WIDTH = 16
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count
  );

  // Count enabled cycles, holding at all-ones; clear has priority.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage sequencing controller: stall arbitration, branch redirect,
// branch-resolution watchdog and stall performance counter.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
  #(
    parameter int unsigned BR_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH  = 16
  )
  (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET_N,
    input  logic                 I_LOCK,
    input  logic                 I_BranchStallSignal,
    input  logic                 I_DepStallSignal,
    input  logic                 I_GPUStallSignal,
    input  logic                 I_BranchAddrSelect,
    output logic [1:0]           O_PCSel,
    output logic [1:0]           O_IRSel,
    output logic                 O_FE_Valid,
    output logic [1:0]           O_State,
    output logic [CNT_WIDTH-1:0] O_StallCount,
    output logic                 O_BrTimeout
  );

  localparam int unsigned WD_W = wd_width(BR_TIMEOUT);
  // The watchdog fires on the edge that would bring the count to BR_TIMEOUT.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(BR_TIMEOUT - 1);

  state_t          state_q;
  state_t          state_d;
  pc_sel_t         pc_sel;
  ir_sel_t         ir_sel;
  logic            fe_valid;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_clr;
  logic            wd_inc;
  logic            wd_fire;
  logic            stall_any;

  assign stall_any = I_GPUStallSignal | I_DepStallSignal;

  // Next-state and Mealy control outputs; I_LOCK low overrides everything.
  always_comb begin
    state_d  = state_q;
    pc_sel   = PC_ZERO;
    ir_sel   = IR_NOP;
    fe_valid = 1'b0;
    wd_clr   = 1'b0;
    wd_inc   = 1'b0;
    wd_fire  = 1'b0;
    if (!I_LOCK) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (I_BranchAddrSelect) begin
            pc_sel = PC_BRANCH;
            ir_sel = IR_NOP;
          end else if (stall_any) begin
            pc_sel   = PC_HOLD;
            ir_sel   = IR_HOLD;
            fe_valid = 1'b1;
          end else if (I_BranchStallSignal) begin
            pc_sel  = PC_HOLD;
            ir_sel  = IR_NOP;
            state_d = ST_BR_WAIT;
            wd_clr  = 1'b1;
          end else begin
            pc_sel   = PC_INC;
            ir_sel   = IR_MEM;
            fe_valid = 1'b1;
          end
        end
        ST_BR_WAIT: begin
          if (I_BranchAddrSelect) begin
            pc_sel  = PC_BRANCH;
            ir_sel  = IR_NOP;
            state_d = ST_RUN;
          end else if (!I_BranchStallSignal) begin
            pc_sel   = PC_INC;
            ir_sel   = IR_MEM;
            fe_valid = 1'b1;
            state_d  = ST_RUN;
          end else if (stall_any) begin
            pc_sel = PC_HOLD;
            ir_sel = IR_NOP;
          end else begin
            pc_sel = PC_HOLD;
            ir_sel = IR_NOP;
            wd_inc = 1'b1;
            if (wd_cnt == WD_LAST) begin
              wd_fire = 1'b1;
              state_d = ST_RUN;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register, watchdog counter and sticky timeout flag.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q     <= ST_IDLE;
      wd_cnt      <= '0;
      O_BrTimeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wd_clr) begin
        wd_cnt <= '0;
      end else if (wd_inc) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_fire) begin
        O_BrTimeout <= 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk    (I_CLOCK),
    .rst_n  (I_RESET_N),
    .enable (pc_sel == PC_HOLD),
    .clear  (1'b0),
    .count  (O_StallCount)
  );

  assign O_PCSel    = pc_sel;
  assign O_IRSel    = ir_sel;
  assign O_FE_Valid = fe_valid;
  assign O_State    = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        lock;
  logic        br_stall;
  logic        dep_stall;
  logic        gpu_stall;
  logic        br_sel;
  logic [1:0]  pc_sel;
  logic [1:0]  ir_sel;
  logic        fe_valid;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        br_timeout;

  int unsigned tests = 0;
  int unsigned fails = 0;

  localparam logic [1:0] INC = 2'd0, HOLD = 2'd1, BRANCH = 2'd2, ZERO = 2'd3;
  localparam logic [1:0] MEM = 2'd0, IRH  = 2'd1, NOP = 2'd2;

  fetch_ctrl #(
    .BR_TIMEOUT (15),
    .CNT_WIDTH  (16)
  ) dut (
    .I_CLOCK             (clk),
    .I_RESET_N           (rst_n),
    .I_LOCK              (lock),
    .I_BranchStallSignal (br_stall),
    .I_DepStallSignal    (dep_stall),
    .I_GPUStallSignal    (gpu_stall),
    .I_BranchAddrSelect  (br_sel),
    .O_PCSel             (pc_sel),
    .O_IRSel             (ir_sel),
    .O_FE_Valid          (fe_valid),
    .O_State             (state),
    .O_StallCount        (stall_cnt),
    .O_BrTimeout         (br_timeout)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] pc, input logic [1:0] ir,
                         input logic v);
    chk({tag, ".pcsel"}, 32'(pc_sel), 32'(pc));
    chk({tag, ".irsel"}, 32'(ir_sel), 32'(ir));
    chk({tag, ".valid"}, 32'(fe_valid), 32'(v));
  endtask

  task automatic chk_st(input string tag, input logic [1:0] st, input int unsigned cnt,
                        input logic to);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".stallcnt"}, 32'(stall_cnt), cnt);
    chk({tag, ".brtimeout"}, 32'(br_timeout), 32'(to));
  endtask

  // Apply inputs just after a falling edge and let the combinational outputs settle.
  task automatic drive(input logic l, input logic bs, input logic ds, input logic gs,
                       input logic ba);
    lock      = l;
    br_stall  = bs;
    dep_stall = ds;
    gpu_stall = gs;
    br_sel    = ba;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    chk_out("reset", ZERO, NOP, 0);
    chk_st("reset", 2'd0, 0, 0);
    #10 rst_n = 1'b1;
    tick();

    // Lock rises: one IDLE cycle, then INC/MEM/1
    drive(1, 0, 0, 0, 0);
    chk_out("idle1", ZERO, NOP, 0);
    chk_st("idle1", 2'd0, 0, 0);
    tick();
    chk_out("run1", INC, MEM, 1);
    chk_st("run1", 2'd1, 0, 0);
    tick();
    chk_out("run2", INC, MEM, 1);

    // Dependency stall for three cycles
    drive(1, 0, 1, 0, 0);
    chk_out("dep1", HOLD, IRH, 1);
    tick();
    chk_out("dep2", HOLD, IRH, 1);
    tick();
    chk_out("dep3", HOLD, IRH, 1);
    tick();
    drive(1, 0, 0, 0, 0);
    chk_out("dep_end", INC, MEM, 1);
    chk_st("dep_end", 2'd1, 3, 0);
    tick();

    // Branch stall for four cycles, then taken redirect
    drive(1, 1, 0, 0, 0);
    chk_out("br_run", HOLD, NOP, 0);
    tick();
    chk_out("br_w1", HOLD, NOP, 0);
    chk_st("br_w1", 2'd2, 4, 0);
    tick();
    chk_out("br_w2", HOLD, NOP, 0);
    tick();
    chk_out("br_w3", HOLD, NOP, 0);
    tick();
    drive(1, 0, 0, 0, 1);
    chk_out("br_take", BRANCH, NOP, 0);
    chk_st("br_take", 2'd2, 7, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    chk_out("br_after", INC, MEM, 1);
    chk_st("br_after", 2'd1, 7, 0);
    tick();

    // Branch not taken
    drive(1, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    chk_out("nt_drop", INC, MEM, 1);
    chk_st("nt_drop", 2'd2, 8, 0);
    tick();
    chk_st("nt_after", 2'd1, 8, 0);

    // Watchdog: 19 wait cycles with GPU stall in wait cycles 3..6
    drive(1, 1, 0, 0, 0);
    tick();
    for (int c = 1; c <= 19; c++) begin
      drive(1, 1, 0, (c >= 3 && c <= 6), 0);
      chk_out($sformatf("wd_c%0d", c), HOLD, NOP, 0);
      chk($sformatf("wd_c%0d.brtimeout", c), 32'(br_timeout), 32'd0);
      chk($sformatf("wd_c%0d.state", c), 32'(state), 32'd2);
      tick();
    end
    drive(1, 1, 0, 0, 0);
    chk_st("wd_fired", 2'd1, 28, 1);
    chk_out("wd_reenter", HOLD, NOP, 0);
    tick();
    chk_st("wd_sticky", 2'd2, 29, 1);

    // Asynchronous reset mid-BR_WAIT
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0);
    chk_out("rst_mid", ZERO, NOP, 0);
    chk_st("rst_mid", 2'd0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_out("rst_run", INC, MEM, 1);
    chk_st("rst_run", 2'd1, 0, 0);

    // Lock drops mid-RUN while a dependency stall is present
    drive(0, 0, 1, 0, 0);
    chk_out("unlock_run", ZERO, NOP, 0);
    tick();
    chk_st("unlock_run", 2'd0, 0, 0);

    // Lock drops mid-BR_WAIT
    drive(1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0);
    tick();
    chk_st("unlock_bw_pre", 2'd2, 1, 0);
    drive(0, 1, 0, 0, 0);
    chk_out("unlock_bw", ZERO, NOP, 0);
    tick();
    chk_st("unlock_bw", 2'd0, 1, 0);

    // Redirect and branch stall together in BR_WAIT: redirect wins, then re-enter
    drive(1, 1, 0, 0, 0);
    chk_out("sim_idle", ZERO, NOP, 0);
    tick();
    tick();
    chk_st("sim_wait", 2'd2, 2, 0);
    drive(1, 1, 0, 0, 1);
    chk_out("sim_both", BRANCH, NOP, 0);
    tick();
    chk_st("sim_run", 2'd1, 2, 0);
    drive(1, 1, 0, 0, 0);
    chk_out("sim_again", HOLD, NOP, 0);
    tick();
    chk_st("sim_rewait", 2'd2, 3, 0);

    // GPU and dependency stall together behave as one stall
    drive(1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 1, 0);
    chk_out("dual_stall", HOLD, IRH, 1);
    tick();
    drive(1, 0, 0, 0, 0);
    chk_out("dual_end", INC, MEM, 1);
    chk_st("dual_end", 2'd1, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
